// File: rtl/alu_dispatch.sv
// rtl/alu_dispatch.sv - issue stage feeding the 16-bit multi-cycle ALU
// Optional DIV0_TRAP_EN: div/mod by zero suppresses writeback and raises div0_trap.
module alu_dispatch #(
    parameter logic [15:0] FR_RESET   = 16'h0000,
    parameter int unsigned EXTRA_WAIT = 0
) (
    input  logic        wire_clock,
    input  logic        wire_reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [2:0]  rf_addr_a,
    output logic [2:0]  rf_addr_b,
    input  logic [15:0] rf_data_a,
    input  logic [15:0] rf_data_b,
    output logic        wb_en,
    output logic [2:0]  wb_addr,
    output logic [15:0] wb_data,
    output logic        enable_alu,
    output logic [15:0] alu_m3,
    output logic [15:0] alu_m4,
    output logic [5:0]  alu_opCode,
    output logic [15:0] alu_FR_in,
    output logic        alu_useCarry,
    output logic        alu_dec,
    output logic [2:0]  alu_flagToShifthAndRot,
    input  logic [15:0] alu_m2,
    input  logic [15:0] alu_FR_out,
    output logic [15:0] fr,
    output logic        done,
`ifdef DIV0_TRAP_EN
    output logic        div0_trap,
`endif
    output logic        illegal
);

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100001;
    localparam logic [5:0] OP_MUL = 6'b100010;
    localparam logic [5:0] OP_DIV = 6'b100011;
    localparam logic [5:0] OP_INC = 6'b100100;
    localparam logic [5:0] OP_MOD = 6'b100101;
    localparam logic [5:0] OP_AND = 6'b010010;
    localparam logic [5:0] OP_OR  = 6'b010011;
    localparam logic [5:0] OP_XOR = 6'b010100;
    localparam logic [5:0] OP_NOT = 6'b010101;
    localparam logic [5:0] OP_CMP = 6'b010110;
    localparam logic [5:0] OP_SHR = 6'b010000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        EXEC  = 3'd2,
        GAP   = 3'd3,
        WB    = 3'd4
    } state_t;

    typedef struct packed {
        logic [1:0]  lat;
        logic        writes;
        logic [15:0] mask;
    } op_info_t;

    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_INC, OP_MOD,
            OP_AND, OP_OR, OP_XOR, OP_NOT, OP_CMP, OP_SHR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Default entry covers the logic ops: LAT 2, writes rx, zero flag only.
    function automatic op_info_t op_decode(input logic [5:0] op);
        op_info_t d;
        d.lat    = 2'd2;
        d.writes = 1'b1;
        d.mask   = 16'h1000;
        case (op)
            OP_ADD: d.mask = 16'h1800;
            OP_SUB: begin d.lat = 2'd3; d.mask = 16'h1040; end
            OP_MUL: d.mask = 16'h1400;
            OP_DIV, OP_MOD: d.mask = 16'h1200;
            OP_INC: begin d.lat = 2'd1; d.mask = 16'h0000; end
            OP_CMP: begin d.lat = 2'd1; d.writes = 1'b0; d.mask = 16'hE000; end
            OP_SHR: begin d.lat = 2'd1; d.mask = 16'h0000; end
            default: ;
        endcase
        return d;
    endfunction

    state_t      state;
    logic [15:0] instr_q;
    op_info_t    info_q;
    logic [2:0]  cnt;
    logic [5:0]  op_q;
    logic [15:0] fr_merge;

    assign op_q        = instr_q[15:10];
    assign instr_ready = (state == IDLE);
    assign rf_addr_a   = instr_q[9:7];
    assign rf_addr_b   = instr_q[6:4];
    assign alu_FR_in   = fr;
    assign fr_merge    = (fr & ~info_q.mask) | (alu_FR_out & info_q.mask);

`ifdef DIV0_TRAP_EN
    logic div0_hit;
    assign div0_hit = ((op_q == OP_DIV) || (op_q == OP_MOD)) && (alu_m4 == 16'h0000);
`endif

    always_ff @(posedge wire_clock) begin
        if (wire_reset) begin
            state                  <= IDLE;
            instr_q                <= 16'h0000;
            info_q                 <= '0;
            cnt                    <= 3'd0;
            enable_alu             <= 1'b0;
            wb_en                  <= 1'b0;
            wb_addr                <= 3'd0;
            wb_data                <= 16'h0000;
            done                   <= 1'b0;
            illegal                <= 1'b0;
            alu_m3                 <= 16'h0000;
            alu_m4                 <= 16'h0000;
            alu_opCode             <= 6'd0;
            alu_useCarry           <= 1'b0;
            alu_dec                <= 1'b0;
            alu_flagToShifthAndRot <= 3'd0;
            fr                     <= FR_RESET;
`ifdef DIV0_TRAP_EN
            div0_trap              <= 1'b0;
`endif
        end else begin
            wb_en   <= 1'b0;
            done    <= 1'b0;
            illegal <= 1'b0;
`ifdef DIV0_TRAP_EN
            div0_trap <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                        info_q  <= op_decode(instr[15:10]);
                        if (op_legal(instr[15:10])) begin
                            state <= LATCH;
                        end else begin
                            // Retire straight away; the ALU is never touched.
                            state   <= WB;
                            done    <= 1'b1;
                            illegal <= 1'b1;
                        end
                    end
                end
                LATCH: begin
                    alu_m3     <= rf_data_a;
                    alu_m4     <= (op_q == OP_SHR) ? {12'h000, instr_q[3:0]} : rf_data_b;
                    alu_opCode <= op_q;
                    alu_useCarry <= ((op_q == OP_ADD) || (op_q == OP_SUB)) && instr_q[0];
                    alu_dec    <= (op_q == OP_INC) && instr_q[0];
                    alu_flagToShifthAndRot <= (op_q == OP_SHR) ? instr_q[6:4] : 3'd0;
                    cnt        <= {1'b0, info_q.lat} + 3'(EXTRA_WAIT);
                    enable_alu <= 1'b1;
                    state      <= EXEC;
                end
                EXEC: begin
                    if (cnt == 3'd0) begin
                        enable_alu <= 1'b0;
                        state      <= GAP;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                GAP: begin
                    // Results land in the WB-cycle outputs so done, wb_en and fr align.
                    wb_data <= alu_m2;
                    wb_addr <= instr_q[9:7];
                    done    <= 1'b1;
                    state   <= WB;
`ifdef DIV0_TRAP_EN
                    if (div0_hit) begin
                        wb_en     <= 1'b0;
                        fr        <= fr_merge | 16'h0200;
                        div0_trap <= 1'b1;
                    end else begin
                        wb_en <= info_q.writes;
                        fr    <= fr_merge;
                    end
`else
                    wb_en <= info_q.writes;
                    fr    <= fr_merge;
`endif
                end
                WB: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
